// File: rtl/shift_reg_pkg.sv
// Shared definitions for the shifting-register serial receive path.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        STOP = 2'b10
    } rx_state_e;

    localparam logic LINE_IDLE = 1'b1;

    // A one-bit counter is still needed when WIDTH=2 ($clog2(2)=1) or smaller.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/shift_rx_buf.sv
// Serial-in/parallel-out register; MSB_FIRST selects which end new bits enter.
module shift_rx_buf
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             shift_en_i,
    input  logic             s_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    // LSB-first streams enter at the top and walk down so the first bit lands in bit 0.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
        end else if (shift_en_i) begin
            data_q <= MSB_FIRST ? {data_q[WIDTH-2:0], s_i} : {s_i, data_q[WIDTH-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/shift_rx_4b.sv
// Framed serial receiver: start/data/stop FSM plus VALID/ACK handshake and error flags.
module shift_rx_4b
    import shift_reg_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic             S_IN,
    input  logic             ACK,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             FRAME_ERR,
    output logic             OVERRUN,
    output logic             BUSY,
    output logic [1:0]       dbg_state_o
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] q_q;
    logic             valid_q;
    logic             ferr_q;
    logic             ovr_q;
    logic [WIDTH-1:0] buf_data;
    logic             shift_en;

    assign shift_en = ENB && (state_q == DATA);

    shift_rx_buf #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_buf (
        .clk_i      (CLK),
        .rst_n_i    (RESET),
        .shift_en_i (shift_en),
        .s_i        (S_IN),
        .data_o     (buf_data)
    );

    // Handshake is checked every edge; a stop-bit sample later in the block
    // overrides it, so a new word arriving with ACK keeps VALID high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (valid_q && ACK) begin
                valid_q <= 1'b0;
                ferr_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end
            if (ENB) begin
                case (state_q)
                    IDLE: begin
                        if (S_IN != LINE_IDLE) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end
                    end
                    DATA: begin
                        if (cnt_q == LAST_BIT) begin
                            state_q <= STOP;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        state_q <= IDLE;
                        q_q     <= buf_data;
                        ferr_q  <= ~S_IN;
                        valid_q <= 1'b1;
                        ovr_q   <= valid_q && !ACK;
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign Q           = q_q;
    assign VALID       = valid_q;
    assign FRAME_ERR   = ferr_q;
    assign OVERRUN     = ovr_q;
    assign BUSY        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
